// File: rtl/bat_anim_controller.sv
// Bat fighter animation sequencer: turns action requests and the frame tick
// into the sprite state code for the colour mapper, plus hitbox/KO flags.
module bat_anim_controller #(
    parameter int FRAME_HOLD = 6
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       left,
    input  logic       right,
    input  logic       punch,
    input  logic       kick,
    input  logic       crouch,
    input  logic       jump,
    input  logic       special,
    input  logic       hit,
    input  logic       ko,
    output logic [5:0] bat,
    output logic       attack_active,
    output logic       busy,
    output logic       ko_done
);

    localparam logic [5:0] HOLD_LAST = 6'(FRAME_HOLD - 1);

    logic [5:0] bat_q, bat_d;
    logic [5:0] cnt_q, cnt_d;
    logic       hp_q, hp_d;
    logic       atk_q, atk_d;
    logic       busy_q, busy_d;
    logic       kod_q, kod_d;

    logic       expire;
    logic       walk;
    logic       hp_now;
    logic       in_ko;
    logic       in_seq;
    logic       in_free;
    logic       in_idle;
    logic       in_walk;
    logic [5:0] seq_next;

    // Classify the current code and the expire condition
    always_comb begin
        expire  = (cnt_q == HOLD_LAST);
        walk    = left ^ right;
        hp_now  = hp_q | hit;
        in_ko   = (bat_q >= 6'd33) && (bat_q <= 6'd35);
        in_idle = (bat_q <= 6'd3);
        in_walk = (bat_q >= 6'd4) && (bat_q <= 6'd7);
        in_free = in_idle || in_walk || (bat_q == 6'd20);
        in_seq  = ((bat_q >= 6'd8) && (bat_q <= 6'd19)) ||
                  ((bat_q >= 6'd21) && (bat_q <= 6'd32));
    end

    // Code that follows a sequenced state when its hold expires
    always_comb begin
        seq_next = bat_q + 6'd1;
        case (bat_q)
            6'd11, 6'd15, 6'd19,
            6'd28, 6'd32: seq_next = 6'd1;
            6'd23:        seq_next = crouch ? 6'd20 : 6'd1;
            6'd35:        seq_next = 6'd35;
            default:      seq_next = bat_q + 6'd1;
        endcase
    end

    // Per-tick state selection, hold counter and pending-hit bookkeeping
    always_comb begin
        bat_d = bat_q;
        cnt_d = cnt_q;
        hp_d  = hp_q | hit;
        if (frame_tick) begin
            hp_d = 1'b0;
            if (in_ko) begin
                bat_d = expire ? seq_next : bat_q;
            end else if (ko) begin
                bat_d = 6'd33;
            end else if (hp_now) begin
                bat_d = 6'd12;
            end else if (in_seq) begin
                bat_d = expire ? seq_next : bat_q;
            end else if (in_free) begin
                if (special) begin
                    bat_d = 6'd29;
                end else if (jump) begin
                    bat_d = 6'd24;
                end else if (punch) begin
                    bat_d = 6'd8;
                end else if (kick) begin
                    bat_d = (bat_q == 6'd20) ? 6'd21 : 6'd16;
                end else if (crouch) begin
                    bat_d = 6'd20;
                end else if (walk) begin
                    if (!in_walk) begin
                        bat_d = 6'd4;
                    end else if (expire) begin
                        bat_d = (bat_q == 6'd7) ? 6'd5 : bat_q + 6'd1;
                    end
                end else if (!in_idle) begin
                    bat_d = 6'd1;
                end else if (expire) begin
                    bat_d = (bat_q == 6'd3) ? 6'd1 : bat_q + 6'd1;
                end
            end else begin
                bat_d = 6'd1;
            end
            cnt_d = (bat_d != bat_q) ? 6'd0 : cnt_q + 6'd1;
        end
    end

    // Output flags derived from the next code so they register with bat
    always_comb begin
        atk_d  = (bat_d == 6'd10) || (bat_d == 6'd18) ||
                 (bat_d == 6'd22) || (bat_d == 6'd31);
        busy_d = ((bat_d >= 6'd8) && (bat_d <= 6'd19)) ||
                 ((bat_d >= 6'd21) && (bat_d <= 6'd35));
        kod_d  = (bat_d == 6'd35);
    end

    // State and registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bat_q  <= 6'd0;
            cnt_q  <= 6'd0;
            hp_q   <= 1'b0;
            atk_q  <= 1'b0;
            busy_q <= 1'b0;
            kod_q  <= 1'b0;
        end else begin
            bat_q  <= bat_d;
            cnt_q  <= cnt_d;
            hp_q   <= hp_d;
            atk_q  <= atk_d;
            busy_q <= busy_d;
            kod_q  <= kod_d;
        end
    end

    assign bat           = bat_q;
    assign attack_active = atk_q;
    assign busy          = busy_q;
    assign ko_done       = kod_q;

endmodule

// File: tb/tb_bat_anim_controller.sv
// Directed bench for bat_anim_controller with a behavioural reference model
// compared every cycle, plus hand-computed literal checkpoints.
module tb_bat_anim_controller;

    localparam int HOLD = 2;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       left = 1'b0, right = 1'b0;
    logic       punch = 1'b0, kick = 1'b0;
    logic       crouch = 1'b0, jump = 1'b0;
    logic       special = 1'b0, hit = 1'b0;
    logic       ko = 1'b0;
    logic [5:0] bat;
    logic       attack_active, busy, ko_done;

    int vectors = 0;
    int errors  = 0;

    int m_bat = 0;
    int m_cnt = 0;
    bit m_hp  = 0;

    bat_anim_controller #(.FRAME_HOLD(HOLD)) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .left(left), .right(right), .punch(punch), .kick(kick),
        .crouch(crouch), .jump(jump), .special(special),
        .hit(hit), .ko(ko), .bat(bat),
        .attack_active(attack_active), .busy(busy), .ko_done(ko_done)
    );

    always #5 Clk = ~Clk;

    // Reference: next sprite code from the priority rules
    function automatic int model_next(int b, int c, bit hpn);
        int first[6] = '{8, 12, 16, 21, 24, 29};
        int last[6]  = '{11, 15, 19, 23, 28, 32};
        bit e = (c == HOLD - 1);
        if (b >= 33 && b <= 35) return (e && b < 35) ? b + 1 : b;
        if (ko) return 33;
        if (hpn) return 12;
        for (int i = 0; i < 6; i++) begin
            if (b >= first[i] && b <= last[i]) begin
                if (!e) return b;
                if (b < last[i]) return b + 1;
                if (b == 23 && crouch) return 20;
                return 1;
            end
        end
        if (special) return 29;
        if (jump) return 24;
        if (punch) return 8;
        if (kick) return (b == 20) ? 21 : 16;
        if (crouch) return 20;
        if (left != right) begin
            if (b < 4 || b > 7) return 4;
            if (!e) return b;
            return (b == 7) ? 5 : b + 1;
        end
        if (b > 3) return 1;
        if (!e) return b;
        return (b == 3) ? 1 : b + 1;
    endfunction

    always @(posedge Clk or posedge Reset) begin
        int nb;
        if (Reset) begin
            m_bat = 0;
            m_cnt = 0;
            m_hp  = 0;
        end else if (frame_tick) begin
            nb = model_next(m_bat, m_cnt, m_hp | hit);
            m_cnt = (nb != m_bat) ? 0 : (m_cnt + 1) % 64;
            m_bat = nb;
            m_hp  = 0;
        end else begin
            m_hp = m_hp | hit;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge Clk) begin
        check("bat", int'(bat), m_bat);
        check("attack_active", int'(attack_active),
              int'(m_bat == 10 || m_bat == 18 || m_bat == 22 || m_bat == 31));
        check("busy", int'(busy),
              int'((m_bat >= 8 && m_bat <= 19) || (m_bat >= 21 && m_bat <= 35)));
        check("ko_done", int'(ko_done), int'(m_bat == 35));
    end

    task automatic tick_once(input bit with_hit);
        @(posedge Clk);
        #1 frame_tick = 1'b1;
        hit = with_hit;
        @(posedge Clk);
        #1 frame_tick = 1'b0;
        hit = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_once(1'b0);
    endtask

    task automatic pulse_hit();
        @(posedge Clk);
        #1 hit = 1'b1;
        @(posedge Clk);
        #1 hit = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #3 Reset = 1'b1;
        #1 check("async_reset", int'(bat), 0);
        left = 0; right = 0; punch = 0; kick = 0; crouch = 0;
        jump = 0; special = 0; hit = 0; ko = 0;
        @(posedge Clk);
        @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        check("reset_bat", int'(bat), 0);
        check("reset_busy", int'(busy), 0);

        // Reset mid-walk, then idle cycle
        right = 1;
        ticks(5);
        check("walk_to_6", int'(bat), 6);
        do_reset();
        ticks(2); check("idle_1", int'(bat), 1);
        ticks(2); check("idle_2", int'(bat), 2);
        ticks(2); check("idle_3", int'(bat), 3);
        ticks(2); check("idle_wrap", int'(bat), 1);

        // Punch with ignored mid-sequence requests
        punch = 1; ticks(1); punch = 0;
        check("punch_8", int'(bat), 8);
        ticks(1); kick = 1; jump = 1;
        ticks(1); check("punch_9", int'(bat), 9);
        ticks(1); kick = 0; jump = 0;
        ticks(1); check("punch_10", int'(bat), 10);
        check("punch_atk", int'(attack_active), 1);
        ticks(2); check("punch_11", int'(bat), 11);
        check("punch_atk_off", int'(attack_active), 0);
        ticks(2); check("punch_done", int'(bat), 1);

        // Crouch kick loop and release
        crouch = 1; ticks(1); check("crouch_20", int'(bat), 20);
        kick = 1; ticks(1); kick = 0;
        check("ckick_21", int'(bat), 21);
        ticks(2); check("ckick_22", int'(bat), 22);
        check("ckick_atk", int'(attack_active), 1);
        ticks(2); check("ckick_23", int'(bat), 23);
        ticks(2); check("ckick_back_20", int'(bat), 20);
        kick = 1; ticks(1); kick = 0;
        ticks(4); check("ckick_23b", int'(bat), 23);
        ticks(1); crouch = 0;
        ticks(1); check("ckick_release", int'(bat), 1);

        // Hit-stun interrupting a kick, then same-cycle hit
        kick = 1; ticks(1); kick = 0;
        ticks(2); check("kick_17", int'(bat), 17);
        pulse_hit();
        ticks(1); check("stun_12", int'(bat), 12);
        check("stun_busy", int'(busy), 1);
        ticks(6); check("stun_15", int'(bat), 15);
        ticks(2); check("stun_done", int'(bat), 1);
        tick_once(1'b1); check("hit_same_cycle", int'(bat), 12);
        ticks(1); check("hit_consumed", int'(bat), 12);
        ticks(1); check("stun_13", int'(bat), 13);
        ticks(6); check("stun_done2", int'(bat), 1);

        // KO during jump
        jump = 1; ticks(1); jump = 0;
        ticks(4); check("jump_26", int'(bat), 26);
        ko = 1; ticks(1); check("ko_33", int'(bat), 33);
        pulse_hit();
        ticks(2); check("ko_34", int'(bat), 34);
        check("ko_done_early", int'(ko_done), 0);
        ticks(2); check("ko_35", int'(bat), 35);
        check("ko_done", int'(ko_done), 1);
        left = 1; punch = 1; kick = 1; crouch = 1; jump = 1; special = 1;
        for (int i = 0; i < 100; i++) tick_once(i[0]);
        check("ko_absorb", int'(bat), 35);
        do_reset();

        // Walk rules and special interrupt
        left = 1; right = 1;
        ticks(2); check("lr_idle_1", int'(bat), 1);
        ticks(2); check("lr_idle_2", int'(bat), 2);
        right = 0;
        ticks(1); check("walk_4", int'(bat), 4);
        ticks(6); check("walk_7", int'(bat), 7);
        ticks(2); check("walk_loop_5", int'(bat), 5);
        special = 1; ticks(1); special = 0; left = 0;
        check("special_29", int'(bat), 29);
        ticks(4); check("special_31", int'(bat), 31);
        check("special_atk", int'(attack_active), 1);
        ticks(4); check("special_done", int'(bat), 1);

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        #1 $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
